wb_initiator_bridge: RTL and testbench
======================================

// Module: wb_initiator_bridge
// PURPOSE
//  Wishbone B4 classic single-access initiator: the master end of the user-area slave bus.
//  Takes one command at a time on a valid/ready port, runs one CYC/STB cycle and returns read data/status.
//  Sits beside the fabric wrapper to drive on-chip Wishbone peripherals from test or fabric logic.
// PARAMETERS
//  ADDR_W         32   address width (wbm_adr_o, cmd_adr)
//  DATA_W         32   data width; SEL width = DATA_W/8
//  TIMEOUT_CYCLES 255  cycles without ack/err before abort (only with WB_INIT_TIMEOUT_EN)
// PORTS
//  wb_clk_i    in  1         single clock, all logic rising-edge
//  wb_rst_ni   in  1         asynchronous active-low reset
//  cmd_valid   in  1         command present
//  cmd_ready   out 1         bridge accepts command this cycle
//  cmd_we      in  1         1=write, 0=read
//  cmd_adr     in  ADDR_W    byte address
//  cmd_dat     in  DATA_W    write data
//  cmd_sel     in  DATA_W/8  byte enables
//  rsp_valid   out 1         response present
//  rsp_ready   in  1         consumer takes response
//  rsp_dat     out DATA_W    read data (0 for writes)
//  rsp_err     out 1         1=bus error or timeout
//  wbm_cyc_o   out 1         WB cycle
//  wbm_stb_o   out 1         WB strobe
//  wbm_we_o    out 1         WB write enable
//  wbm_sel_o   out DATA_W/8  WB byte select
//  wbm_adr_o   out ADDR_W    WB address
//  wbm_dat_o   out DATA_W    WB write data
//  wbm_dat_i   in  DATA_W    WB read data
//  wbm_ack_i   in  1         WB acknowledge
//  wbm_err_i   in  1         WB error
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all outputs 0 except cmd_ready=1.
//  FSM IDLE -> BUS -> RESP -> IDLE. cmd_ready=1 only in IDLE; rsp_valid=1 only in RESP.
//  IDLE: cmd_valid&cmd_ready registers cmd into wbm_* and sets cyc=stb=1 next cycle (state BUS).
//  BUS: wbm_* held stable. First cycle with ack_i or err_i: cyc=stb=0 next cycle; capture
//   rsp_dat=wbm_dat_i if read & ack, else 0; rsp_err=err_i; -> RESP. ack&err together: err wins, rsp_dat=0.
//  Minimum latency cmd accept -> rsp_valid: 2 cycles (1 accept, 1 ack in first BUS cycle).
//  RESP: rsp_* held until rsp_ready; then -> IDLE (cmd_ready=1 next cycle; no back-to-back overlap).
//  ack_i/err_i while not in BUS are ignored. wbm_dat_o/we/sel/adr are don't-care when cyc=0 but hold last value.
//  Async reset mid-BUS drops cyc/stb immediately; the in-flight command is discarded, no response.
// CONFIGURATION
//  WB_INIT_TIMEOUT_EN defined: counter clears on BUS entry, increments each BUS cycle without ack/err;
//   on reaching TIMEOUT_CYCLES drop cyc/stb, -> RESP with rsp_err=1, rsp_dat=0.
//   ack/err arriving in the same cycle as expiry wins over timeout.
//  Not defined: no counter; BUS waits indefinitely for ack/err.
// STRUCTURE
//  wb_initiator_pkg: state enum (IDLE,BUS,RESP), SEL_W localparam, default TIMEOUT constant.
//  Sub-module wb_init_timeout_ctr (clear/enable/expire, width $clog2(TIMEOUT_CYCLES+1)),
//   instantiated only under WB_INIT_TIMEOUT_EN.
// TESTING
//  Write adr=0x3000_0004 dat=0xDEADBEEF sel=0xF, ack after 3 cycles -> wbm_* stable 3 cycles, rsp_err=0, rsp_dat=0.
//  Read adr=0x3000_0000, slave ack in 1st BUS cycle with dat=0x1234_5678 -> rsp_dat=0x12345678, rsp_valid 2 cycles after accept.
//  Read with err_i=1 (ack_i=1 same cycle) -> rsp_err=1, rsp_dat=0, cyc dropped next cycle.
//  rsp_ready held 0 for 10 cycles, cmd_valid=1 -> cmd_ready=0 throughout, rsp_* stable, no new cyc.
//  TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> cyc low after 8 BUS cycles, rsp_err=1; without macro cyc stays high.
//  wb_rst_ni pulsed low mid-BUS -> cyc/stb=0 same cycle, cmd_ready=1 after release, no rsp_valid.

Source files
------------

// File: rtl/wb_initiator_pkg.sv
// Shared types and defaults for the Wishbone B4 classic single-access initiator.
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int SEL_W       = DEF_DATA_W / 8;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/wb_init_timeout_ctr.sv
// Bus-cycle watchdog: counts BUS cycles that saw no ack/err and flags the
// cycle in which the TIMEOUT_CYCLES-th such cycle is being spent.
module wb_init_timeout_ctr
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    // Count idle BUS cycles; cleared when a new command is accepted, saturates at the limit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Expiry is combinational so the FSM leaves BUS at the end of the last allowed cycle.
    assign o_expire = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/wb_initiator_bridge.sv
// Wishbone B4 classic single-access initiator (master end of the user-area bus).
// One command at a time: accept on cmd_valid/cmd_ready, run one CYC/STB cycle,
// return status/read data on rsp_valid/rsp_ready.
// Optional feature: define WB_INIT_TIMEOUT_EN to abort a bus cycle that sees no
// ack/err within TIMEOUT_CYCLES cycles (reported as rsp_err=1).
module wb_initiator_bridge
    import wb_initiator_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    // command port
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    // response port
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    // Wishbone master
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    state_t r_state;
    state_t w_state_nxt;

    logic                w_bus;
    logic                w_accept;
    logic                w_done;
    logic                w_timeout;

    logic                r_we;
    logic [DATA_W/8-1:0] r_sel;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic [DATA_W-1:0]   r_rsp_dat;
    logic                r_rsp_err;

    assign w_bus    = (r_state == ST_BUS);
    assign w_accept = (r_state == ST_IDLE) && cmd_valid;
    // ack/err outside BUS never reach this term, so they are ignored there.
    assign w_done   = w_bus && (wbm_ack_i || wbm_err_i || w_timeout);

`ifdef WB_INIT_TIMEOUT_EN
    wb_init_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .i_clk    (wb_clk_i),
        .i_rst_n  (wb_rst_ni),
        .i_clear  (w_accept),
        .i_enable (w_bus && !wbm_ack_i && !wbm_err_i),
        .o_expire (w_timeout)
    );
`else
    // No watchdog: the expression is constant-false, BUS waits for ack/err indefinitely.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State register; async reset drops CYC/STB immediately and discards any in-flight command.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> BUS on accept, BUS -> RESP on ack/err/timeout, RESP -> IDLE on rsp_ready.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (cmd_valid) w_state_nxt = ST_BUS;
            ST_BUS:  if (w_done)    w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: handshake and CYC/STB are pure functions of the registered state.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        case (r_state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Command capture: WB request fields latch on accept and hold through BUS and afterwards.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_we  <= 1'b0;
            r_sel <= '0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (w_accept) begin
            r_we  <= cmd_we;
            r_sel <= cmd_sel;
            r_adr <= cmd_adr;
            r_dat <= cmd_dat;
        end
    end

    // Response capture on bus completion; err (or timeout) forces zero data, writes always return zero.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
        end else if (w_done) begin
            r_rsp_err <= wbm_err_i || w_timeout;
            r_rsp_dat <= (!r_we && wbm_ack_i && !wbm_err_i) ? wbm_dat_i : '0;
        end
    end

    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_wb_initiator_bridge.sv
// Self-checking bench for wb_initiator_bridge: scoreboard of expected responses,
// bench-driven Wishbone slave behaviour. Covers both builds of WB_INIT_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_wb_initiator_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o, wbm_dat_i;
    logic          wbm_ack_i, wbm_err_i;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] dat;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    wb_initiator_bridge #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every completed response handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            chk("sb_q_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_rsp_err", rsp_err, e.err);
                chk("sb_rsp_dat", rsp_dat, e.dat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
    endtask

    // Present a command and return one cycle after the accepting edge (DUT now in BUS).
    task automatic issue(input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        int waited;
        waited    = 0;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("accept_wait", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b1;
        slave_idle();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("rst_we_sel", {wbm_we_o, wbm_sel_o}, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_dat_o", wbm_dat_o, 0);
        chk("rst_rsp", {rsp_err, rsp_dat}, 0);
        rst_n = 1'b1;
        tick();

        // write, ack on the third BUS cycle; slave drives junk read data that must not leak
        sb_q.push_back(rsp_t'{err: 1'b0, dat: 32'h0});
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        for (int c = 0; c < 3; c++) begin
            chk("wr_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b11);
            chk("wr_we", wbm_we_o, 1);
            chk("wr_adr", wbm_adr_o, 32'h3000_0004);
            chk("wr_dat", wbm_dat_o, 32'hDEAD_BEEF);
            chk("wr_sel", wbm_sel_o, 4'hF);
            chk("wr_cmd_ready", cmd_ready, 0);
            if (c == 2) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'hFFFF_FFFF;
            end
            tick();
        end
        slave_idle();
        chk("wr_cyc_drop", wbm_cyc_o, 0);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_dat", rsp_dat, 0);
        tick();
        chk("wr_back_idle", {cmd_ready, rsp_valid}, 2'b10);

        // read, ack in first BUS cycle: rsp_valid two cycles after accept
        sb_q.push_back(rsp_t'{err: 1'b0, dat: 32'h1234_5678});
        issue(1'b0, 32'h3000_0000, 32'h0BAD_F00D, 4'hF);
        chk("rd_rsp_early", rsp_valid, 0);
        chk("rd_cyc_we", {wbm_cyc_o, wbm_we_o}, 2'b10);
        chk("rd_adr", wbm_adr_o, 32'h3000_0000);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        tick();
        slave_idle();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_cyc_drop", wbm_cyc_o, 0);
        chk("rd_rsp_dat", rsp_dat, 32'h1234_5678);
        tick();

        // read with err and ack together: err wins, data forced to zero
        sb_q.push_back(rsp_t'{err: 1'b1, dat: 32'h0});
        issue(1'b0, 32'h3000_0008, 32'h0, 4'h3);
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'hCAFE_F00D;
        tick();
        slave_idle();
        chk("err_cyc_drop", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("err_rsp_err", rsp_err, 1);
        chk("err_rsp_dat", rsp_dat, 0);
        tick();

        // response back-pressure with a new command waiting
        sb_q.push_back(rsp_t'{err: 1'b0, dat: 32'hA5A5_0F0F});
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hA5A5_0F0F;
        tick();
        slave_idle();
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h1111_2222;
        for (int c = 0; c < 10; c++) begin
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp", {rsp_err, rsp_dat}, {1'b0, 32'hA5A5_0F0F});
            chk("bp_no_cyc", wbm_cyc_o, 0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_released", {cmd_ready, rsp_valid, wbm_cyc_o}, 3'b100);

        // ack/err outside BUS are ignored
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        tick();
        slave_idle();
        chk("stray_state", {cmd_ready, rsp_valid, wbm_cyc_o}, 3'b100);

`ifdef WB_INIT_TIMEOUT_EN
        // no ack: watchdog aborts after TMO BUS cycles
        begin
            int nbus;
            nbus = 0;
            sb_q.push_back(rsp_t'{err: 1'b1, dat: 32'h0});
            issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
            while (wbm_cyc_o && nbus < 50) begin
                nbus++;
                tick();
            end
            chk("tmo_bus_cycles", nbus, TMO);
            chk("tmo_rsp", {rsp_valid, rsp_err}, 2'b11);
            tick();
        end
`else
        // no ack: without the watchdog CYC stays asserted until the slave answers
        sb_q.push_back(rsp_t'{err: 1'b0, dat: 32'h0F1E_2D3C});
        issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        for (int c = 0; c < 20; c++) begin
            chk("notmo_cyc", {wbm_cyc_o, rsp_valid}, 2'b10);
            tick();
        end
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0F1E_2D3C;
        tick();
        slave_idle();
        chk("notmo_rsp_valid", rsp_valid, 1);
        tick();
`endif

        // async reset mid-BUS: CYC/STB drop at once, command discarded without response
        issue(1'b1, 32'h3000_0010, 32'h5555_AAAA, 4'h1);
        chk("mrst_cyc_before", wbm_cyc_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
        tick();
        rst_n = 1'b1;
        chk("mrst_cmd_ready", cmd_ready, 1);
        for (int c = 0; c < 3; c++) begin
            chk("mrst_no_rsp", {rsp_valid, wbm_cyc_o}, 0);
            tick();
        end

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
